instr_fetch_unit: RTL and testbench

- Front end of the miniRV core. Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers the returned words with their PCs in a small FIFO and presents them to the decode stage over a valid/ready interface.
- Takes PC redirects from execute (branch/JAL/JALR) and squashes wrong-path instructions, including a fetch already in flight.

---
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// miniRV fetch front end: owns the PC, issues single-outstanding word fetches,
// buffers returned words with their PCs and hands them to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        KILL     = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   req_pc;
    logic          req_fire;
    logic          req_valid_next;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];

    // FIFO head presentation; an empty buffer shows a NOP at PC 0
    always_comb begin
        instr_valid = (count != {CW{1'b0}});
        if (instr_valid) begin
            instruction = fifo_instr[rd_ptr];
            instr_pc    = fifo_pc[rd_ptr];
        end else begin
            instruction = NOP;
            instr_pc    = 32'h0000_0000;
        end
    end

    // Next-state, PC and FIFO occupancy; redirect overrides everything
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        req_fire   = imem_req_valid && imem_req_ready;
        pop        = instr_valid && instr_ready;
        if (redirect_valid) begin
            pc_next = redirect_pc & 32'hFFFF_FFFC;
            // an accepted or still-pending fetch must have its response dropped
            if (req_fire) begin
                state_next = KILL;
            end else if ((state != FETCH) && !imem_rsp_valid) begin
                state_next = KILL;
            end else begin
                state_next = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire) begin
                        state_next = WAIT_RSP;
                        pc_next    = pc + 32'd4;
                    end else begin
                        state_next = FETCH;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        push       = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WAIT_RSP;
                    end
                end
                KILL: begin
                    if (imem_rsp_valid) begin
                        state_next = FETCH;
                    end else begin
                        state_next = KILL;
                    end
                end
                default: state_next = FETCH;
            endcase
        end

        if (redirect_valid) begin
            count_next = {CW{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end

        // outside FETCH a request is outstanding, so only FETCH needs the credit test
        req_valid_next = (state_next == FETCH) && (count_next < DEPTH_C);
    end

    // State, PC and registered request channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            req_pc         <= 32'h0000_0000;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            imem_req_valid <= req_valid_next;
            imem_req_addr  <= pc_next;
            if (req_fire) begin
                req_pc <= pc;
            end else begin
                req_pc <= req_pc;
            end
        end
    end

    // Instruction buffer storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= {CW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            wr_ptr <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= NOP;
                fifo_pc[i]    <= 32'h0000_0000;
            end
        end else begin
            count <= count_next;
            if (redirect_valid) begin
                rd_ptr <= {PW{1'b0}};
                wr_ptr <= {PW{1'b0}};
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rsp_data;
                    fifo_pc[wr_ptr]    <= req_pc;
                    wr_ptr             <= wr_ptr + PW'(1);
                end else begin
                    wr_ptr <= wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end else begin
                    rd_ptr <= rd_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue-based fetch model checked every cycle,
// plus hand-computed address/instruction expectations for each scenario.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;

    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_instr_valid;
    logic [31:0] w_instruction, w_instr_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .instr_valid(w_instr_valid), .instr_ready(1'b1),
        .instruction(w_instruction), .instr_pc(w_instr_pc)
    );

    int errors = 0;
    int checks = 0;

    // stimulus controls
    logic        mem_ready = 1'b1;
    logic        nx_ready  = 1'b1;
    logic        nx_redir  = 1'b0;
    logic [31:0] nx_rpc    = 32'h0000_0000;
    int          lat       = 1;
    int          pend      = 0;
    logic [31:0] pend_addr = 32'h0000_0000;
    logic        w_pend    = 1'b0;
    logic [31:0] w_pend_addr = 32'h0000_0000;

    // observation logs
    logic [31:0] issued[$];
    logic [31:0] dec_pc[$];
    logic [31:0] dec_ins[$];
    logic [31:0] w_addrs[$];
    logic [31:0] w_dec_pc[$];
    logic [31:0] w_dec_ins[$];

    // behavioural model
    logic        m_started, m_out, m_killed;
    logic [31:0] m_pc, m_out_pc;
    logic [31:0] m_qpc[$];
    logic [31:0] m_qins[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic m_req_valid();
        return m_started && !m_out && (m_qpc.size() < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // advance the model over the clock edge just passed, using the inputs applied to it
    task automatic model_update();
        logic fire, rsp, pop;
        if (rst) begin
            m_started = 1'b0; m_out = 1'b0; m_killed = 1'b0;
            m_pc = RPC; m_out_pc = 32'h0000_0000;
            m_qpc.delete(); m_qins.delete();
        end else begin
            fire = m_req_valid() && imem_req_ready;
            rsp  = imem_rsp_valid && m_out;
            pop  = (m_qpc.size() != 0) && instr_ready;
            if (redirect_valid) begin
                m_qpc.delete(); m_qins.delete();
                if (rsp) begin
                    m_out = 1'b0; m_killed = 1'b0;
                end else if (m_out) begin
                    m_killed = 1'b1;
                end
                if (fire) begin
                    m_out = 1'b1; m_killed = 1'b1;
                end
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (pop) begin
                    void'(m_qpc.pop_front());
                    void'(m_qins.pop_front());
                end
                if (rsp) begin
                    if (!m_killed) begin
                        m_qpc.push_back(m_out_pc);
                        m_qins.push_back(memword(m_out_pc));
                    end
                    m_out = 1'b0; m_killed = 1'b0;
                end
                if (fire) begin
                    m_out_pc = m_pc; m_pc = m_pc + 32'd4; m_out = 1'b1;
                end
            end
            m_started = 1'b1;
        end
    endtask

    task automatic tick();
        logic exp_rv;
        @(negedge clk);
        model_update();
        exp_rv = m_req_valid();
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (m_qpc.size() != 0)});
        chk("instruction", instruction, (m_qpc.size() != 0) ? m_qins[0] : NOP);
        chk("instr_pc", instr_pc, (m_qpc.size() != 0) ? m_qpc[0] : 32'h0000_0000);
    endtask

    // apply inputs for the current cycle and run both memory models
    task automatic drive();
        imem_req_ready = mem_ready;
        instr_ready    = nx_ready;
        redirect_valid = nx_redir;
        redirect_pc    = nx_rpc;
        nx_redir       = 1'b0;
        imem_rsp_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memword(pend_addr);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            issued.push_back(imem_req_addr);
            pend_addr = imem_req_addr;
            pend      = lat;
        end
        if (instr_valid && instr_ready) begin
            dec_pc.push_back(instr_pc);
            dec_ins.push_back(instruction);
        end
        w_req_ready = 1'b1;
        w_rsp_valid = w_pend;
        w_rsp_data  = memword(w_pend_addr);
        w_pend      = w_req_valid;
        if (w_req_valid) begin
            w_pend_addr = w_req_addr;
            if (w_addrs.size() < 3) w_addrs.push_back(w_req_addr);
        end
        if (w_instr_valid && (w_dec_pc.size() < 3)) begin
            w_dec_pc.push_back(w_instr_pc);
            w_dec_ins.push_back(w_instruction);
        end
    endtask

    task automatic cyc();
        tick();
        drive();
    endtask

    task automatic clear_logs();
        issued.delete(); dec_pc.delete(); dec_ins.delete();
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; pend = 0; nx_redir = 1'b0; drive();
        cyc();
        tick(); rst = 1'b0; drive();
        clear_logs();
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'bx;
    endfunction

    initial begin
        int idx;
        logic found;
        rst = 1'b1;
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0000_0000;
        redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'h0000_0000;

        tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0000_0000);
        drive();
        tick(); rst = 1'b0; drive();
        clear_logs();

        // streaming at k=1 with decode always ready
        lat = 1; mem_ready = 1'b1; nx_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("t1_addr0", qget(issued, 0), 32'h0000_0100);
        chk("t1_addr1", qget(issued, 1), 32'h0000_0104);
        chk("t1_addr2", qget(issued, 2), 32'h0000_0108);
        chk("t1_dec0_pc", qget(dec_pc, 0), 32'h0000_0100);
        chk("t1_dec0_ins", qget(dec_ins, 0), 32'h1357_9ADF);
        chk("t1_dec1_pc", qget(dec_pc, 1), 32'h0000_0104);
        chk("t1_dec1_ins", qget(dec_ins, 1), 32'h1357_9ADB);
        chk("t1_dec2_pc", qget(dec_pc, 2), 32'h0000_0108);
        chk("t1_dec2_ins", qget(dec_ins, 2), 32'h1357_9AD7);

        // decode stalled: credit caps requests at the buffer depth
        do_reset();
        nx_ready = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        chk("t2_issued_cnt", 32'(issued.size()), 32'd2);
        chk("t2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("t2_head_pc", instr_pc, 32'h0000_0100);
        chk("t2_head_ins", instruction, 32'h1357_9ADF);
        nx_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("t2_resume_addr", qget(issued, 2), 32'h0000_0108);

        // redirect while waiting on the response for 0x104
        do_reset();
        lat = 3;
        for (int g = 0; g < 40 && issued.size() < 2; g++) cyc();
        chk("t3_reach_wait", 32'(issued.size()), 32'd2);
        tick(); nx_redir = 1'b1; nx_rpc = 32'h0000_0203; drive();
        dec_pc.delete(); dec_ins.delete();
        tick();
        chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
        drive();
        for (int i = 0; i < 14; i++) cyc();
        chk("t3_next_addr", qget(issued, 2), 32'h0000_0200);
        chk("t3_dec_pc", qget(dec_pc, 0), 32'h0000_0200);
        chk("t3_dec_ins", qget(dec_ins, 0), 32'h1357_99DF);

        // redirect coinciding with an accepted request and a decode pop
        do_reset();
        lat = 1;
        found = 1'b0;
        for (int g = 0; g < 40 && !found; g++) begin
            tick();
            if (instr_valid && imem_req_valid) begin
                found = 1'b1; nx_redir = 1'b1; nx_rpc = 32'h0000_0300;
            end
            drive();
        end
        chk("t4_found", {31'd0, found}, 32'd1);
        idx = issued.size();
        dec_pc.delete(); dec_ins.delete();
        tick();
        chk("t4_flushed", {31'd0, instr_valid}, 32'd0);
        drive();
        for (int i = 0; i < 8; i++) cyc();
        chk("t4_restart_addr", qget(issued, idx), 32'h0000_0300);
        chk("t4_dec_pc", qget(dec_pc, 0), 32'h0000_0300);
        chk("t4_dec_ins", qget(dec_ins, 0), 32'h1357_98DF);

        // asynchronous reset while a response is still in flight
        do_reset();
        lat = 3;
        for (int g = 0; g < 40 && issued.size() < 1; g++) cyc();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("t6_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_instruction", instruction, NOP);
        chk("t6_instr_pc", instr_pc, 32'h0000_0000);
        drive();
        tick(); rst = 1'b0; drive();
        clear_logs();
        for (int i = 0; i < 10; i++) cyc();
        chk("t6_first_addr", qget(issued, 0), 32'h0000_0100);
        chk("t6_dec_pc", qget(dec_pc, 0), 32'h0000_0100);

        // PC wrap on the second instance
        chk("wrap_addr0", qget(w_addrs, 0), 32'hFFFF_FFF8);
        chk("wrap_addr1", qget(w_addrs, 1), 32'hFFFF_FFFC);
        chk("wrap_addr2", qget(w_addrs, 2), 32'h0000_0000);
        chk("wrap_dec_pc", qget(w_dec_pc, 0), 32'hFFFF_FFF8);
        chk("wrap_dec_ins", qget(w_dec_ins, 0), 32'hECA8_6427);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
